// File: rtl/cl_tcdm_port_buffer_pkg.sv
// Shared types and widths for the TCDM port buffer: one request beat as a packed struct.
package cl_tcdm_buf_pkg;

    localparam int TCDM_DW  = 32;
    localparam int TCDM_AW  = 32;
    localparam int TCDM_BEW = 4;

    // One queued TCDM request. wen follows TCDM convention: 1 = read, 0 = write.
    typedef struct packed {
        logic [TCDM_AW-1:0]  add;
        logic                wen;
        logic [TCDM_DW-1:0]  wdata;
        logic [TCDM_BEW-1:0] be;
    } tcdm_req_t;

endpackage

// File: rtl/cl_tcdm_port_buffer_if.sv
// Multi-lane TCDM bus bundle. Each lane is an independent req/gnt channel.
// Handshake: a request transfers on a cycle where req and gnt are both high;
// while req is high and gnt low the request fields stay stable. Responses
// (r_valid/r_rdata) are one-cycle pulses, in order, and are always accepted.
interface cl_tcdm_port_buffer_if
    import cl_tcdm_buf_pkg::*;
#(
    parameter int NB_PORTS = 4
);
    logic [NB_PORTS-1:0]               req;
    logic [NB_PORTS-1:0][TCDM_AW-1:0]  add;
    logic [NB_PORTS-1:0]               wen;
    logic [NB_PORTS-1:0][TCDM_DW-1:0]  wdata;
    logic [NB_PORTS-1:0][TCDM_BEW-1:0] be;
    logic [NB_PORTS-1:0]               gnt;
    logic [NB_PORTS-1:0]               r_valid;
    logic [NB_PORTS-1:0][TCDM_DW-1:0]  r_rdata;

    modport master (
        output req, add, wen, wdata, be,
        input  gnt, r_valid, r_rdata
    );

    modport slave (
        input  req, add, wen, wdata, be,
        output gnt, r_valid, r_rdata
    );
endinterface

// File: rtl/cl_tcdm_port_buffer_lane_fifo.sv
// Per-lane request FIFO. No bypass: a pushed entry appears at head one cycle later.
module cl_tcdm_lane_fifo
    import cl_tcdm_buf_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      push,
    input  tcdm_req_t wdata,
    input  logic      pop,
    output tcdm_req_t head,
    output logic      full,
    output logic      empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    tcdm_req_t      mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic           push_ok;
    logic           pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Pointer and occupancy tracking; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // Storage write; contents need no reset since occupancy gates visibility.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/cl_tcdm_port_buffer.sv
// Per-lane request buffer between the AXI-to-TCDM converter and the cluster
// TCDM interconnect. Each lane queues requests, limits granted-but-unanswered
// requests, and forwards responses unchanged. busy_o/err_o aggregate lanes.
module cl_tcdm_port_buffer
    import cl_tcdm_buf_pkg::*;
#(
    parameter int NB_PORTS        = 4,
    parameter int DEPTH           = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    cl_tcdm_port_buffer_if.slave   slv,
    cl_tcdm_port_buffer_if.master  mst,
    output logic                   busy_o,
    output logic                   err_o
);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    tcdm_req_t           push_data [NB_PORTS];
    tcdm_req_t           head      [NB_PORTS];
    logic                full      [NB_PORTS];
    logic                empty     [NB_PORTS];
    logic [CNT_W-1:0]    cnt_q     [NB_PORTS];

    logic [NB_PORTS-1:0] push;
    logic [NB_PORTS-1:0] pop;
    logic [NB_PORTS-1:0] issue;
    logic [NB_PORTS-1:0] gnt;
    logic [NB_PORTS-1:0] err_hit;

    logic [NB_PORTS-1:0]               req_vec;
    logic [NB_PORTS-1:0][TCDM_AW-1:0]  add_vec;
    logic [NB_PORTS-1:0]               wen_vec;
    logic [NB_PORTS-1:0][TCDM_DW-1:0]  wdata_vec;
    logic [NB_PORTS-1:0][TCDM_BEW-1:0] be_vec;

    for (genvar g = 0; g < NB_PORTS; g++) begin : g_lane
        cl_tcdm_lane_fifo #(
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .push  (push[g]),
            .wdata (push_data[g]),
            .pop   (pop[g]),
            .head  (head[g]),
            .full  (full[g]),
            .empty (empty[g])
        );
    end

    // Per-lane accept, issue gating, pop and protocol-error detection.
    always_comb begin
        for (int i = 0; i < NB_PORTS; i++) begin
            push_data[i] = '{add: slv.add[i], wen: slv.wen[i], wdata: slv.wdata[i], be: slv.be[i]};
            gnt[i]       = ~full[i];
            push[i]      = slv.req[i] & ~full[i];
            issue[i]     = ~empty[i] & (cnt_q[i] < CNT_W'(MAX_OUTSTANDING));
            pop[i]       = issue[i] & mst.gnt[i];
            // A pop in the same cycle covers the response, so it is not an error.
            err_hit[i]   = mst.r_valid[i] & (cnt_q[i] == '0) & ~pop[i];
            req_vec[i]   = issue[i];
            add_vec[i]   = head[i].add;
            wen_vec[i]   = head[i].wen;
            wdata_vec[i] = head[i].wdata;
            be_vec[i]    = head[i].be;
        end
    end

    assign slv.gnt     = gnt;
    assign slv.r_valid = mst.r_valid;
    assign slv.r_rdata = mst.r_rdata;
    assign mst.req     = req_vec;
    assign mst.add     = add_vec;
    assign mst.wen     = wen_vec;
    assign mst.wdata   = wdata_vec;
    assign mst.be      = be_vec;

    // Outstanding counters: +1 per issued request, -1 per response, saturating at 0.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NB_PORTS; i++) begin
            if (rst_i) begin
                cnt_q[i] <= '0;
            end else begin
                case ({pop[i], mst.r_valid[i]})
                    2'b10:   cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                    2'b01:   if (cnt_q[i] != '0) cnt_q[i] <= cnt_q[i] - CNT_W'(1);
                    default: cnt_q[i] <= cnt_q[i];
                endcase
            end
        end
    end

    // Sticky error flag for responses that match no outstanding request.
    always_ff @(posedge clk_i) begin
        if (rst_i) err_o <= 1'b0;
        else if (|err_hit) err_o <= 1'b1;
    end

    // Busy whenever any lane has queued or in-flight work (state only).
    always_comb begin
        busy_o = 1'b0;
        for (int i = 0; i < NB_PORTS; i++) begin
            if (!empty[i] || (cnt_q[i] != '0)) busy_o = 1'b1;
        end
    end
endmodule
